// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bundle for bin_to_bcd_seq.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) ();
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BCD_LZ_BLANK_EN to generate the leading-zero blanking mask.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;
  localparam int TW = DW + WIDTH;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic             fin;
  logic [WIDTH-1:0] shreg, shreg_sh;
  logic [DW-1:0]    dig, adj, dig_sh;
  logic [TW-1:0]    cat, cat_sh;
  logic             out_bit;
  logic             sticky;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic [DW-1:0]    bcd_q;
  logic             ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    unique case (state)
      IDLE:  if (io.start) state_nxt = SHIFT;
      SHIFT: if (cnt == CW'(1)) begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adj = dig;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig[4*k +: 4] >= 4'd5) adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
    end
    cat      = {adj, shreg};
    cat_sh   = cat << 1;
    out_bit  = cat[TW-1];
    dig_sh   = cat_sh[TW-1:WIDTH];
    shreg_sh = cat_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      dig    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (state == IDLE) begin
        if (io.start) begin
          shreg  <= io.bin;
          dig    <= '0;
          sticky <= 1'b0;
          cnt    <= CW'(WIDTH);
        end
      end else begin
        shreg  <= shreg_sh;
        dig    <= dig_sh;
        sticky <= sticky | out_bit;
        cnt    <= cnt - CW'(1);
        if (fin) begin
          bcd_q <= dig_sh;
          ovf_q <= sticky | out_bit;
        end
      end
    end
  end

`ifdef BCD_LZ_BLANK_EN
  localparam logic [DIGITS-1:0] LZ_RST = {DIGITS{1'b1}} << 1;

  logic [DIGITS-1:0] lz, blank_q;

  // Zero run scanned from the top digit down; digit 0 always shown
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (dig_sh[DW-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      lz[k] = lz[k+1] && (dig_sh[4*k +: 4] == 4'd0);
    end
    lz[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      blank_q <= LZ_RST;
    else if (fin) blank_q <= lz;
  end

  assign io.blank = blank_q;
`else
  assign io.blank = '0;
`endif

  assign io.busy = (state == SHIFT);
  assign io.done = done_q;
  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq at three geometries.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat, lat2, ndone;

`ifdef BCD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) i16 ();
  bin_to_bcd_seq_if #(.WIDTH(14), .DIGITS(4)) i14 ();
  bin_to_bcd_seq_if #(.WIDTH(1),  .DIGITS(1)) i1 ();

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) d16 (
    .clk(clk), .rst(rst), .io(i16));
  bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) d14 (
    .clk(clk), .rst(rst), .io(i14));
  bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) d1 (
    .clk(clk), .rst(rst), .io(i1));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run16(input logic [15:0] v, output int n);
    @(negedge clk);
    i16.bin = v;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    chk("busy16", 32'(i16.busy), 1);
    n = 0;
    while (!i16.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle16", 32'(i16.busy), 0);
  endtask

  task automatic run14(input logic [13:0] v, output int n);
    @(negedge clk);
    i14.bin = v;
    i14.start = 1'b1;
    @(negedge clk);
    i14.start = 1'b0;
    n = 0;
    while (!i14.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle14", 32'(i14.busy), 0);
  endtask

  task automatic run1(input logic v, output int n);
    @(negedge clk);
    i1.bin = v;
    i1.start = 1'b1;
    @(negedge clk);
    i1.start = 1'b0;
    n = 0;
    while (!i1.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle1", 32'(i1.busy), 0);
  endtask

  initial begin
    i16.start = 1'b0; i16.bin = '0;
    i14.start = 1'b0; i14.bin = '0;
    i1.start  = 1'b0; i1.bin  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(i16.busy), 0);
    chk("rst_done", 32'(i16.done), 0);
    chk("rst_bcd", 32'(i16.bcd), 0);
    chk("rst_ovf", 32'(i16.ovf), 0);
    chk("rst_blank", 32'(i16.blank), LZ ? 32'h1e : 32'h0);
    chk("rst_blank1", 32'(i1.blank), 0);
    rst = 1'b0;

    run16(16'hffff, lat);
    chk("ffff_lat", lat, 16);
    chk("ffff_bcd", 32'(i16.bcd), 32'h65535);
    chk("ffff_ovf", 32'(i16.ovf), 0);
    chk("ffff_blank", 32'(i16.blank), 0);
    @(negedge clk);
    chk("done_pulse", 32'(i16.done), 0);

    run14(14'd9999, lat);
    chk("9999_lat", lat, 14);
    chk("9999_bcd", 32'(i14.bcd), 32'h9999);
    chk("9999_ovf", 32'(i14.ovf), 0);
    run14(14'd10000, lat);
    chk("10000_bcd", 32'(i14.bcd), 32'h0000);
    chk("10000_ovf", 32'(i14.ovf), 1);
    chk("10000_blank", 32'(i14.blank), LZ ? 32'he : 32'h0);
    run14(14'd12345, lat);
    chk("12345_bcd", 32'(i14.bcd), 32'h2345);
    chk("12345_ovf", 32'(i14.ovf), 1);

    run16(16'd0, lat);
    chk("zero_bcd", 32'(i16.bcd), 0);
    chk("zero_blank", 32'(i16.blank), LZ ? 32'h1e : 32'h0);
    run16(16'd42, lat);
    chk("42_bcd", 32'(i16.bcd), 32'h42);
    chk("42_blank", 32'(i16.blank), LZ ? 32'h1c : 32'h0);

    // start and bin disturbed mid-conversion, then back-to-back start
    @(negedge clk);
    i16.bin = 16'd100;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(negedge clk);
      lat++;
    end
    i16.bin = 16'd7;
    i16.start = 1'b1;
    @(negedge clk);
    lat++;
    i16.start = 1'b0;
    while (!i16.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_lat", lat, 16);
    chk("mid_bcd", 32'(i16.bcd), 32'h100);
    i16.bin = 16'd250;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    lat2 = 1;
    while (!i16.done && lat2 < 60) begin
      @(negedge clk);
      lat2++;
    end
    chk("b2b_lat", lat2, 17);
    chk("b2b_bcd", 32'(i16.bcd), 32'h250);
    chk("b2b_blank", 32'(i16.blank), LZ ? 32'h18 : 32'h0);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    i16.bin = 16'hffff;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(i16.busy), 0);
    chk("mrst_bcd", 32'(i16.bcd), 0);
    chk("mrst_blank", 32'(i16.blank), LZ ? 32'h1e : 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (i16.done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    run16(16'd1234, lat);
    chk("1234_lat", lat, 16);
    chk("1234_bcd", 32'(i16.bcd), 32'h01234);
    chk("1234_blank", 32'(i16.blank), LZ ? 32'h10 : 32'h0);

    run1(1'b1, lat);
    chk("w1_lat", lat, 1);
    chk("w1_bcd", 32'(i1.bcd), 1);
    chk("w1_ovf", 32'(i1.ovf), 0);
    run1(1'b0, lat);
    chk("w1_zero", 32'(i1.bcd), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
